mbox_cyc_arb: RTL
=================

Name: mbox_cyc_arb

Overview:
- Arbitrates and sequences MBOX memory cycles among three requesters:
  - EBOX, driven from the MCL cycle request and VMA context.
  - Channel (CHAN).
  - Cache-sweep engine (CCA).
- Sole driver of the MBOX request port. Owns grant, request/ack handshake, completion and timeout.
- Holds the read-pause-write (RPW) interlock so no other requester is granted between the EBOX read and its write-back.

Parameters:
- AW, 23: physical/virtual address width carried to MBOX (bits 13:35).
- CCA_STARVE, 8: consecutive CCA losses before CCA is promoted to top priority for one grant.
- TIMEOUT, 64: cycles allowed from MB_ACK to completion before NXM error (used only with the optional feature).

Ports:
- clk  in  1  MBOX/MCL clock
- RESET  in  1  synchronous active-high reset (MR reset)
- EBOX_REQ  in  1  EBOX cycle request (level, held until EBOX_DONE)
- EBOX_WR  in  1  EBOX cycle is a write
- EBOX_RPW  in  1  EBOX read is read-pause-write (ignored when EBOX_WR=1)
- EBOX_ADR  in  AW  EBOX address
- CHAN_REQ  in  1  channel request (level)
- CHAN_WR  in  1  channel write
- CHAN_ADR  in  AW  channel address
- CCA_REQ  in  1  cache sweep request (level; always a write-back)
- CCA_ADR  in  AW  sweep address
- EBOX_GNT, CHAN_GNT, CCA_GNT  out  1  current owner, one-hot or zero
- EBOX_DONE, CHAN_DONE, CCA_DONE  out  1  one-cycle completion pulse
- EBOX_ERR, CHAN_ERR, CCA_ERR  out  1  asserted with DONE on NXM timeout
- MB_REQ  out  1  request to MBOX
- MB_WR  out  1  request is a write
- MB_ADR  out  AW  request address
- MB_SRC  out  2  source: 0 EBOX, 1 CHAN, 2 CCA
- MB_ACK  in  1  MBOX accepted request
- MB_CPL  in  1  MBOX read data valid or write complete
- RPW_LOCK  out  1  RPW interlock held
- BUSY  out  1  state != IDLE

Behaviour:
- All outputs are registered.
- Reset value of every output is 0. Reset also clears the state to IDLE, the starvation count, the lock and the timer.
- Reset mid-cycle abandons the cycle with no DONE pulse.

States: IDLE, ISSUE, WAIT, LOCK.

IDLE:
- Samples requests and picks a winner.
- Default priority: CHAN > EBOX > CCA.
- If the starvation count equals CCA_STARVE and CCA_REQ=1, CCA wins instead.
- Starvation count:
  - Increments when CCA_REQ=1 and CCA loses. Saturates at CCA_STARVE.
  - Clears when CCA is granted.
- On a winner, in the next cycle:
  - GNT of the winner = 1.
  - MB_REQ = 1.
  - MB_WR, MB_ADR and MB_SRC are captured from the winner's inputs.
  - State goes to ISSUE.
- Winner-to-MB_REQ latency is 1 cycle.

ISSUE:
- MB_REQ and the address/type signals hold stable until MB_ACK.
- On MB_ACK, MB_REQ drops the next cycle and the state goes to WAIT.
- If MB_ACK and MB_CPL arrive in the same cycle, the cycle completes directly (same as the WAIT completion).

WAIT:
- On MB_CPL, the owner's DONE pulses for one cycle and GNT drops in the same cycle.
- Next state:
  - If the owner is EBOX and the cycle was an RPW read: state goes to LOCK, RPW_LOCK = 1, and EBOX_GNT is kept at 1.
  - Otherwise: IDLE.
- MB_CPL outside WAIT/ISSUE is ignored.

LOCK:
- Only EBOX may be granted. CHAN and CCA wait, and the CCA starvation count does not advance.
- On EBOX_REQ=1 with EBOX_WR=1 and EBOX_ADR equal to the captured address:
  - Issue the write.
  - Go to ISSUE.
  - RPW_LOCK clears on the write's DONE.
- An EBOX request with a different address, or a read, is still issued but keeps the lock.

General rules:
- A new arbitration never starts in the same cycle as DONE; at least one IDLE cycle separates cycles.
- Dropping a requester's REQ after grant does not abort the cycle.

Optional Feature:
- Macro: MBOX_CYC_TIMEOUT_EN.
- Defined:
  - A counter starts at MB_ACK and counts cycles in WAIT.
  - On reaching TIMEOUT without MB_CPL, the owner's DONE and ERR pulse together, GNT drops, and the state goes to IDLE.
  - A timeout in an RPW read or its write clears RPW_LOCK.
  - A timeout in ISSUE (no MB_ACK) also fires after TIMEOUT cycles.
- Undefined: no counter. WAIT and ISSUE hold indefinitely and ERR outputs are tied 0.

Test Plan:
- Basic read:
  - Stimulus: EBOX_REQ=1, EBOX_WR=0, ADR=0x1234. MB_ACK 2 cycles after MB_REQ, MB_CPL 3 cycles later.
  - Required: MB_REQ asserts 1 cycle after IDLE sample with MB_SRC=0 and MB_ADR=0x1234. EBOX_DONE is a single pulse. BUSY returns to 0.
- Priority:
  - Stimulus: CHAN_REQ, EBOX_REQ and CCA_REQ all asserted in the same cycle.
  - Required: grant order CHAN, EBOX, CCA across three cycles, each separated by at least one IDLE cycle.
- Starvation:
  - Stimulus: CCA_REQ held while CHAN_REQ is continuously re-asserted.
  - Required: CCA granted on the 9th arbitration (CCA_STARVE=8). Count then resets.
- RPW interlock:
  - Stimulus: EBOX RPW read at 0x40, then CHAN_REQ asserts.
  - Required: RPW_LOCK=1 and CHAN_GNT stays 0 until the EBOX write to 0x40 completes. CHAN is granted next.
- Edge and reset:
  - ACK+CPL in the same cycle → DONE one cycle later, with no WAIT state visited.
  - RESET asserted in WAIT → all outputs 0 next cycle and no DONE.
- Timeout (MBOX_CYC_TIMEOUT_EN):
  - Stimulus: MB_ACK given, MB_CPL withheld.
  - Required: CHAN_DONE and CHAN_ERR pulse 64 cycles after ACK. State returns to IDLE.

Source files
------------

// File: rtl/mbox_cyc_arb.sv
// MBOX cycle arbiter: grants EBOX/CHAN/CCA, drives the MBOX request port and holds the RPW interlock.
// Optional build macro MBOX_CYC_TIMEOUT_EN adds an NXM timeout on ISSUE/WAIT (ERR outputs otherwise tied low).
module mbox_cyc_arb #(
    parameter int AW         = 23,
    parameter int CCA_STARVE = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic          clk,
    input  logic          RESET,
    input  logic          EBOX_REQ,
    input  logic          EBOX_WR,
    input  logic          EBOX_RPW,
    input  logic [AW-1:0] EBOX_ADR,
    input  logic          CHAN_REQ,
    input  logic          CHAN_WR,
    input  logic [AW-1:0] CHAN_ADR,
    input  logic          CCA_REQ,
    input  logic [AW-1:0] CCA_ADR,
    output logic          EBOX_GNT,
    output logic          CHAN_GNT,
    output logic          CCA_GNT,
    output logic          EBOX_DONE,
    output logic          CHAN_DONE,
    output logic          CCA_DONE,
    output logic          EBOX_ERR,
    output logic          CHAN_ERR,
    output logic          CCA_ERR,
    output logic          MB_REQ,
    output logic          MB_WR,
    output logic [AW-1:0] MB_ADR,
    output logic [1:0]    MB_SRC,
    input  logic          MB_ACK,
    input  logic          MB_CPL,
    output logic          RPW_LOCK,
    output logic          BUSY
);
    localparam int SW = $clog2(CCA_STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(CCA_STARVE);
    localparam logic [1:0] SRC_EBOX = 2'd0;
    localparam logic [1:0] SRC_CHAN = 2'd1;
    localparam logic [1:0] SRC_CCA  = 2'd2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, LOCK} state_t;

    state_t        state_q;
    logic [2:0]    gnt_q, done_q;
    logic          mb_req_q, mb_wr_q, busy_q;
    logic [AW-1:0] mb_adr_q, lock_adr_q;
    logic [1:0]    mb_src_q;
    logic          rpw_rd_q, rel_wr_q, rpw_lock_q;
    logic [SW-1:0] starve_q, starve_d;

    logic [2:0]    win_oh;
    logic          win_wr;
    logic [AW-1:0] win_adr;
    logic [1:0]    win_src;
    logic          cpl_now, arb_ok;

    always_comb begin
        win_oh   = 3'b000;
        win_wr   = 1'b0;
        win_adr  = '0;
        win_src  = SRC_EBOX;
        starve_d = starve_q;
        if (CCA_REQ && starve_q == STARVE_MAX) begin
            win_oh = 3'b100; win_wr = 1'b1; win_adr = CCA_ADR; win_src = SRC_CCA;
        end else if (CHAN_REQ) begin
            win_oh = 3'b010; win_wr = CHAN_WR; win_adr = CHAN_ADR; win_src = SRC_CHAN;
        end else if (EBOX_REQ) begin
            win_oh = 3'b001; win_wr = EBOX_WR; win_adr = EBOX_ADR; win_src = SRC_EBOX;
        end else if (CCA_REQ) begin
            win_oh = 3'b100; win_wr = 1'b1; win_adr = CCA_ADR; win_src = SRC_CCA;
        end
        if (win_oh[2])
            starve_d = '0;
        else if (CCA_REQ && starve_q != STARVE_MAX)
            starve_d = starve_q + SW'(1);
    end

    // Requesters still hold REQ during their DONE cycle, so no arbitration then.
    assign arb_ok  = ~|done_q;
    assign cpl_now = (state_q == ISSUE && MB_ACK && MB_CPL) || (state_q == WAIT && MB_CPL);

`ifdef MBOX_CYC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] timer_q;
    logic [2:0]    err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q    <= IDLE;
            gnt_q      <= 3'b000;
            done_q     <= 3'b000;
            mb_req_q   <= 1'b0;
            mb_wr_q    <= 1'b0;
            mb_adr_q   <= '0;
            mb_src_q   <= 2'd0;
            lock_adr_q <= '0;
            rpw_rd_q   <= 1'b0;
            rel_wr_q   <= 1'b0;
            rpw_lock_q <= 1'b0;
            busy_q     <= 1'b0;
            starve_q   <= '0;
`ifdef MBOX_CYC_TIMEOUT_EN
            timer_q    <= '0;
            err_q      <= 3'b000;
`endif
        end else begin
            done_q <= 3'b000;
`ifdef MBOX_CYC_TIMEOUT_EN
            err_q  <= 3'b000;
`endif
            case (state_q)
                IDLE: if (arb_ok) begin
                    starve_q <= starve_d;
                    if (|win_oh) begin
                        gnt_q    <= win_oh;
                        mb_req_q <= 1'b1;
                        mb_wr_q  <= win_wr;
                        mb_adr_q <= win_adr;
                        mb_src_q <= win_src;
                        rpw_rd_q <= win_oh[0] & EBOX_RPW & ~EBOX_WR;
                        rel_wr_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ISSUE;
`ifdef MBOX_CYC_TIMEOUT_EN
                        timer_q  <= '0;
`endif
                    end
                end
                ISSUE: begin
                    if (MB_ACK) begin
                        mb_req_q <= 1'b0;
                        state_q  <= WAIT;
`ifdef MBOX_CYC_TIMEOUT_EN
                        timer_q  <= '0;
                    end else if (timer_q == TO_LAST) begin
                        done_q <= gnt_q; err_q <= gnt_q; gnt_q <= 3'b000; mb_req_q <= 1'b0;
                        rpw_lock_q <= 1'b0; busy_q <= 1'b0; state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
`endif
                    end
                end
                WAIT: begin
`ifdef MBOX_CYC_TIMEOUT_EN
                    if (!MB_CPL) begin
                        if (timer_q == TO_LAST) begin
                            done_q <= gnt_q; err_q <= gnt_q; gnt_q <= 3'b000;
                            rpw_lock_q <= 1'b0; busy_q <= 1'b0; state_q <= IDLE;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
`endif
                end
                LOCK: if (arb_ok && EBOX_REQ) begin
                    // Only the write back to the locked address releases the interlock.
                    mb_req_q <= 1'b1;
                    mb_wr_q  <= EBOX_WR;
                    mb_adr_q <= EBOX_ADR;
                    mb_src_q <= SRC_EBOX;
                    rpw_rd_q <= 1'b0;
                    rel_wr_q <= EBOX_WR && (EBOX_ADR == lock_adr_q);
                    state_q  <= ISSUE;
`ifdef MBOX_CYC_TIMEOUT_EN
                    timer_q  <= '0;
`endif
                end
                default: state_q <= IDLE;
            endcase

            if (cpl_now) begin
                done_q <= gnt_q;
                if (rel_wr_q) begin
                    gnt_q <= 3'b000; rpw_lock_q <= 1'b0; busy_q <= 1'b0; state_q <= IDLE;
                end else if (rpw_lock_q) begin
                    state_q <= LOCK;
                end else if (rpw_rd_q) begin
                    rpw_lock_q <= 1'b1; lock_adr_q <= mb_adr_q; state_q <= LOCK;
                end else begin
                    gnt_q <= 3'b000; busy_q <= 1'b0; state_q <= IDLE;
                end
            end
        end
    end

    assign {CCA_GNT, CHAN_GNT, EBOX_GNT}    = gnt_q;
    assign {CCA_DONE, CHAN_DONE, EBOX_DONE} = done_q;
`ifdef MBOX_CYC_TIMEOUT_EN
    assign {CCA_ERR, CHAN_ERR, EBOX_ERR}    = err_q;
`else
    assign {CCA_ERR, CHAN_ERR, EBOX_ERR}    = 3'b000;
`endif
    assign MB_REQ   = mb_req_q;
    assign MB_WR    = mb_wr_q;
    assign MB_ADR   = mb_adr_q;
    assign MB_SRC   = mb_src_q;
    assign RPW_LOCK = rpw_lock_q;
    assign BUSY     = busy_q;
endmodule
